// File: rtl/axistream_forwarder_pkg.sv
// ---------------------------------------------------------------------------
// axistream_forwarder_pkg
// Constants shared by the capture (snooper) and transmit (forwarder) sides of
// the packet memory, plus the forwarder FSM state encoding.
//   AXIS_DATA_WIDTH  : default AXIS TDATA / packet memory read width in bits
//   PMEM_ADDR_WIDTH  : packet memory address width (32-bit word addresses)
//   PMEM_RD_LATENCY  : cycles from rd_en to valid rd_data
//   fwdState_t       : forwarder FSM states
// ---------------------------------------------------------------------------
package axistream_forwarder_pkg;

   localparam int AXIS_DATA_WIDTH = 64;
   localparam int PMEM_ADDR_WIDTH = 10;
   localparam int PMEM_RD_LATENCY = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } fwdState_t;

endpackage

// File: rtl/axistream_forwarder_fifo.sv
// ---------------------------------------------------------------------------
// axis_out_fifo2
// Two-entry register FIFO that decouples packet memory read data from the
// AXIS master port. The head entry is driven straight from storage registers
// so the AXIS outputs never depend combinationally on the memory read data.
//   clk, rst  : clock, asynchronous active-high reset (clears storage too)
//   push_i    : write wrData_i this cycle
//   pop_i     : remove the head entry this cycle
//   wrData_i  : entry to write
//   rdData_o  : head entry
//   count_o   : number of valid entries (0..2)
//   full_o    : two entries held
//   empty_o   : no entries held
// ---------------------------------------------------------------------------
module axis_out_fifo2 #(
   parameter int WIDTH = 73
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wrData_i,
   output logic [WIDTH-1:0] rdData_o,
   output logic [1:0]       count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wrPtr_q;
   logic             rdPtr_q;
   logic [1:0]       count_q;
   logic             doPush;
   logic             doPop;

   assign full_o   = (count_q == 2'd2);
   assign empty_o  = (count_q == 2'd0);
   assign count_o  = count_q;
   assign rdData_o = mem_q[rdPtr_q];

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign doPop  = pop_i & ~empty_o;
   assign doPush = push_i & (~full_o | doPop);

   // Storage, pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wrPtr_q  <= 1'b0;
         rdPtr_q  <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= wrData_i;
            wrPtr_q        <= ~wrPtr_q;
         end
         if (doPop) begin
            rdPtr_q <= ~rdPtr_q;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/axistream_forwarder.sv
// ---------------------------------------------------------------------------
// axistream_forwarder
// Transmit side of the packet memory: reads one stored packet and sends it on
// an AXI Stream master port, honouring TREADY backpressure, then pulses done.
// Addresses count 32-bit words, matching the capture path's layout.
//   clk, rst   : clock, asynchronous active-high reset
//   pkt_ready  : packet memory holds a complete packet (sampled in IDLE only)
//   pkt_len    : packet length in bytes, valid while pkt_ready is high
//   rd_addr    : packet memory read address (32-bit word units)
//   rd_en      : read strobe, rd_data valid one cycle later
//   rd_data    : packet memory read data
//   done       : one-cycle pulse once the whole packet has been sent
//   TDATA/TKEEP/TVALID/TREADY/TLAST : AXIS master port
// ---------------------------------------------------------------------------
module axistream_forwarder
   import axistream_forwarder_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int ADDR_WIDTH = PMEM_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pkt_ready,
   input  logic [ADDR_WIDTH+1:0]   pkt_len,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic                    rd_en,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   TDATA,
   output logic [DATA_WIDTH/8-1:0] TKEEP,
   output logic                    TVALID,
   input  logic                    TREADY,
   output logic                    TLAST
);

   localparam int BPB  = DATA_WIDTH / 8;
   localparam int STEP = DATA_WIDTH / 32;
   localparam int CW   = ADDR_WIDTH + 2;
   localparam int KW   = $clog2(BPB);
   localparam int EW   = DATA_WIDTH + BPB + 1;

   fwdState_t             state_q;
   logic [CW-1:0]         beats_q;
   logic [CW-1:0]         readCnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BPB-1:0]        lastKeep_q;
   logic                  inFlight_q;
   logic                  inFlightLast_q;
   logic [BPB-1:0]        inFlightKeep_q;
   logic                  done_q;

   logic [CW-1:0]         beats_d;
   logic [BPB-1:0]        lastKeep_d;
   logic [KW-1:0]         lenRem;
   logic [EW-1:0]         fifoHead;
   logic [1:0]            fifoCount;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic                  fifoPop;
   logic [2:0]            occupancy;
   logic                  creditOk;
   logic                  isLastRead;
   logic                  drained;

   // Words returned by the memory are tagged with the keep/last computed when
   // the read was issued, so the FIFO carries complete beats.
   axis_out_fifo2 #(
      .WIDTH (EW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (inFlight_q),
      .pop_i    (fifoPop),
      .wrData_i ({inFlightLast_q, inFlightKeep_q, rd_data}),
      .rdData_o (fifoHead),
      .count_o  (fifoCount),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty)
   );

   assign {TLAST, TKEEP, TDATA} = fifoHead;
   assign TVALID  = ~fifoEmpty;
   assign fifoPop = TVALID & TREADY;
   assign done    = done_q;
   assign rd_addr = addr_q;

   // Beat count is ceil(len / BPB); the last beat keeps only the remainder bytes.
   assign lenRem  = pkt_len[KW-1:0];
   assign beats_d = CW'(pkt_len[CW-1:KW]) + CW'(|lenRem);

   always_comb begin
      lastKeep_d = '0;
      for (int i = 0; i < BPB; i++) begin
         lastKeep_d[i] = (lenRem == '0) || (KW'(i) < lenRem);
      end
   end

   // Credit: buffered plus in-flight words never exceed the two FIFO slots.
   // A head leaving this cycle frees its slot, which keeps one beat per cycle
   // flowing when TREADY stays high.
   assign occupancy  = 3'(fifoCount) + 3'(inFlight_q);
   assign creditOk   = (occupancy < 3'd2) || (fifoPop && (occupancy == 3'd2));
   assign rd_en      = (state_q == ST_FETCH) && creditOk;
   assign isLastRead = (readCnt_q == beats_q - CW'(1));

   // The FIFO is empty after this edge with nothing left to arrive, so done
   // can follow the TLAST transfer by a single cycle.
   assign drained = !inFlight_q && (fifoEmpty || (!fifoFull && fifoPop));

   // Control FSM, address/beat counters and in-flight read tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         beats_q        <= '0;
         readCnt_q      <= '0;
         addr_q         <= '0;
         lastKeep_q     <= '0;
         inFlight_q     <= 1'b0;
         inFlightLast_q <= 1'b0;
         inFlightKeep_q <= '0;
         done_q         <= 1'b0;
      end else begin
         inFlight_q <= rd_en;
         if (rd_en) begin
            inFlightLast_q <= isLastRead;
            inFlightKeep_q <= isLastRead ? lastKeep_q : '1;
         end
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pkt_ready) begin
                  if (pkt_len != '0) begin
                     beats_q    <= beats_d;
                     lastKeep_q <= lastKeep_d;
                     readCnt_q  <= '0;
                     addr_q     <= '0;
                     state_q    <= ST_FETCH;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_FETCH: begin
               if (rd_en) begin
                  addr_q    <= addr_q + ADDR_WIDTH'(STEP);
                  readCnt_q <= readCnt_q + CW'(1);
                  if (isLastRead) begin
                     state_q <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               if (drained) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axistream_forwarder.sv
// ---------------------------------------------------------------------------
// tb_axistream_forwarder
// Directed bench for axistream_forwarder with a one-cycle packet memory model
// whose beat k (address 2k) returns {salt, k}.
// ---------------------------------------------------------------------------
module tb_axistream_forwarder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pkt_ready = 1'b0;
   logic [11:0] pkt_len = '0;
   logic [9:0]  rd_addr;
   logic        rd_en;
   logic [63:0] rd_data = '0;
   logic        done;
   logic [63:0] TDATA;
   logic [7:0]  TKEEP;
   logic        TVALID;
   logic        TREADY = 1'b1;
   logic        TLAST;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int launchCyc = 0;
   int lastXferCyc = 0;
   int readyMode = 0;
   int rdyCyc = 0;
   logic [31:0] salt = '0;

   logic [63:0] gotData [$];
   logic [7:0]  gotKeep [$];
   logic        gotLast [$];
   int          addrQ [$];
   int          doneQ [$];
   int          validRise [$];

   int          issued = 0;
   int          xferred = 0;
   logic        prevStall = 1'b0;
   logic        prevValid = 1'b0;
   logic [63:0] prevData = '0;
   logic [7:0]  prevKeep = '0;
   logic        prevLast = 1'b0;

   axistream_forwarder dut (
      .clk       (clk),
      .rst       (rst),
      .pkt_ready (pkt_ready),
      .pkt_len   (pkt_len),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .done      (done),
      .TDATA     (TDATA),
      .TKEEP     (TKEEP),
      .TVALID    (TVALID),
      .TREADY    (TREADY),
      .TLAST     (TLAST)
   );

   always #5 clk = ~clk;

   // Cycle counter: at the negedge after posedge k, cyc equals k.
   always @(posedge clk) cyc <= cyc + 1;

   // Packet memory model with one cycle of read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= {salt, 32'(rd_addr >> 1)};
   end

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Observes the bus mid-cycle: logs reads, beats and done pulses, checks
   // that a stalled beat holds steady and that outstanding words stay <= 2.
   always @(negedge clk) begin
      if (rst) begin
         issued    = 0;
         xferred   = 0;
         prevStall = 1'b0;
         prevValid = 1'b0;
      end else begin
         if (prevStall)
            checkOutput("holdStable", {TVALID, TLAST, TKEEP, TDATA},
                        {1'b1, prevLast, prevKeep, prevData});
         if (rd_en) begin
            addrQ.push_back(int'(rd_addr));
            issued++;
         end
         if (TVALID && TREADY) begin
            gotData.push_back(TDATA);
            gotKeep.push_back(TKEEP);
            gotLast.push_back(TLAST);
            xferred++;
            if (TLAST) lastXferCyc = cyc;
         end
         if (TVALID && !prevValid) validRise.push_back(cyc);
         if (done) doneQ.push_back(cyc);
         checkOutput("occupancy", ((issued - xferred) <= 2), 1);
         prevStall = TVALID && !TREADY;
         prevValid = TVALID;
         prevData  = TDATA;
         prevKeep  = TKEEP;
         prevLast  = TLAST;
      end
   end

   task automatic clearLog();
      gotData.delete();
      gotKeep.delete();
      gotLast.delete();
      addrQ.delete();
      doneQ.delete();
      validRise.delete();
      rdyCyc = 0;
   endtask

   // Offers one packet: pkt_ready is high across exactly one rising edge.
   task automatic applyStimulus(input int len);
      @(negedge clk);
      clearLog();
      pkt_len   = 12'(len);
      pkt_ready = 1'b1;
      launchCyc = cyc;
      @(negedge clk);
      pkt_ready = 1'b0;
   endtask

   task automatic waitDone(input int n);
      int t = 0;
      while (doneQ.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      checkOutput("doneSeen", (doneQ.size() >= n), 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic checkBeats(input int base, input int len);
      int n;
      logic [7:0] k;
      n = (len + 7) / 8;
      for (int i = 0; i < n; i++) begin
         k = 8'hFF;
         if (i == n - 1 && (len % 8) != 0) k = 8'((1 << (len % 8)) - 1);
         checkOutput("tdata", gotData[base + i], {salt, 32'(i)});
         checkOutput("tkeep", gotKeep[base + i], k);
         checkOutput("tlast", gotLast[base + i], (i == n - 1));
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Sink ready pattern, updated just after each rising edge.
      fork
         forever begin
            @(posedge clk);
            #1;
            rdyCyc++;
            case (readyMode)
               1:       TREADY = (rdyCyc >= 6 && rdyCyc <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
               2:       TREADY = (gotData.size() < 2);
               default: TREADY = 1'b1;
            endcase
         end
      join_none

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rstValid", {TVALID, rd_en, done, TLAST}, 4'b0000);
      checkOutput("rstAddr", rd_addr, 10'd0);
      checkOutput("rstBus", {TKEEP, TDATA}, 72'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 24 bytes, sink always ready: 3 full beats, back to back.
      salt = 32'h0;
      applyStimulus(24);
      waitDone(1);
      checkOutput("t1Beats", gotData.size(), 3);
      checkBeats(0, 24);
      checkOutput("t1Reads", addrQ.size(), 3);
      checkOutput("t1Addr0", addrQ[0], 0);
      checkOutput("t1Addr1", addrQ[1], 2);
      checkOutput("t1Addr2", addrQ[2], 4);
      checkOutput("t1FirstValid", validRise[0], launchCyc + 3);
      checkOutput("t1LastXfer", lastXferCyc, launchCyc + 5);
      checkOutput("t1DoneTime", doneQ[0], lastXferCyc + 1);
      checkOutput("t1DoneCount", doneQ.size(), 1);

      // 13 bytes: partial last beat.
      salt = 32'h1234_5678;
      applyStimulus(13);
      waitDone(1);
      checkOutput("t2Beats", gotData.size(), 2);
      checkBeats(0, 13);
      checkOutput("t2Keep", gotKeep[1], 8'h1F);

      // Zero-length packet: no beats, done right after acceptance.
      applyStimulus(0);
      waitDone(1);
      checkOutput("t4Done", doneQ[0], launchCyc + 1);
      checkOutput("t4DoneCount", doneQ.size(), 1);
      checkOutput("t4NoValid", validRise.size(), 0);
      checkOutput("t4NoReads", addrQ.size(), 0);

      // 64 bytes with random backpressure and a 5-cycle stall.
      salt = 32'hCAFE_0003;
      readyMode = 1;
      applyStimulus(64);
      waitDone(1);
      readyMode = 0;
      checkOutput("t3Beats", gotData.size(), 8);
      checkBeats(0, 64);
      checkOutput("t3DoneTime", doneQ[0], lastXferCyc + 1);

      // Reset while beat 3 of 8 is stalled.
      salt = 32'h5555_0005;
      readyMode = 2;
      applyStimulus(64);
      for (int t = 0; t < 100 && gotData.size() < 2; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      checkOutput("t5Stalled", {TVALID, TREADY}, 2'b10);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5AsyncDrop", {TVALID, rd_en, done}, 3'b000);
      checkOutput("t5AsyncBus", {TLAST, TKEEP, TDATA}, 73'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      readyMode = 0;
      checkOutput("t5NoDone", doneQ.size(), 0);
      salt = 32'h0000_0016;
      applyStimulus(16);
      waitDone(1);
      checkOutput("t5Beats", gotData.size(), 2);
      checkBeats(0, 16);
      checkOutput("t5Restart", addrQ[0], 0);

      // Back-to-back packets with pkt_ready held across the first done.
      salt = 32'h0000_0B2B;
      @(negedge clk);
      clearLog();
      pkt_len   = 12'd16;
      pkt_ready = 1'b1;
      for (int t = 0; t < 100 && doneQ.size() < 1; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      pkt_ready = 1'b0;
      waitDone(2);
      checkOutput("t6Beats", gotData.size(), 4);
      checkBeats(0, 16);
      checkBeats(2, 16);
      checkOutput("t6DoneCount", doneQ.size(), 2);
      checkOutput("t6Gap", ((validRise[1] - doneQ[0]) >= 3), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
